subleq_ctrl: RTL and testbench



---
 rtl/subleq_ctrl_pkg.sv | 42 ++++
 rtl/subleq_ram_port.sv | 106 ++++++++++
 rtl/subleq_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_subleq_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/subleq_ctrl_pkg.sv
// Shared definitions for the SUBLEQ controller and its RAM port.
// Holds the bus/data widths, the active-low RAM bus levels, the controller
// state encodings, the RAM-port phase encodings and the branch predicate.
package subleq_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // RAM control bus levels (ope/ena active low, ctl selects direction)
    localparam logic BUS_EN  = 1'b0;
    localparam logic BUS_DIS = 1'b1;
    localparam logic CTL_WR  = 1'b0;
    localparam logic CTL_RD  = 1'b1;

    // Controller states
    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] FA   = 4'd1;
    localparam logic [3:0] FB   = 4'd2;
    localparam logic [3:0] FC   = 4'd3;
    localparam logic [3:0] RA   = 4'd4;
    localparam logic [3:0] RB   = 4'd5;
    localparam logic [3:0] TA   = 4'd6;
    localparam logic [3:0] WSET = 4'd7;
    localparam logic [3:0] WSTB = 4'd8;
    localparam logic [3:0] WREL = 4'd9;
    localparam logic [3:0] BR   = 4'd10;
    localparam logic [3:0] HALT = 4'd11;

    // RAM port access phases
    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_R1   = 3'd1;
    localparam logic [2:0] P_R2   = 3'd2;
    localparam logic [2:0] P_W1   = 3'd3;
    localparam logic [2:0] P_W2   = 3'd4;
    localparam logic [2:0] P_W3   = 3'd5;

    // Branch predicate: result is zero or negative as a signed byte
    function automatic logic is_leq(input logic [DATA_W-1:0] d);
        return d[DATA_W-1] | (d == '0);
    endfunction

endpackage

// File: rtl/subleq_ram_port.sv
// RAM access sequencer for the SUBLEQ controller.
// A read occupies two cycles (R1, R2) with ena/ope asserted; the data is
// valid for capture by the caller at the end of R2 (done=1 in R2).
// A write occupies three cycles: setup with data driven, ctl low strobe,
// release with data still driven (done=1 in the release cycle).
// A new access may be started while idle or in the done cycle of the
// previous access, giving back-to-back reads without bubbles.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start, wr       begin an access; wr=1 write, wr=0 read
//   addr, wdata     access address and write data, sampled with start
//   done            last cycle of the current access
//   rdata           RAM data bus as seen by the reader
//   ope, ctl, ena   registered active-low RAM control bus
//   adr             registered RAM address
//   dat             RAM data bus, driven only during the write phases
module subleq_ram_port
    import subleq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              ope,
    output logic              ctl,
    output logic              ena,
    output logic [ADDR_W-1:0] adr,
    inout  wire  [DATA_W-1:0] dat
);

    logic [2:0]        phase;
    logic [2:0]        phase_nxt;
    logic              accept;
    logic              oe;
    logic [DATA_W-1:0] wdata_q;

    assign done   = (phase == P_R2) || (phase == P_W3);
    assign accept = start && ((phase == P_IDLE) || done);

    always_comb begin
        phase_nxt = P_IDLE;
        case (phase)
            P_R1:    phase_nxt = P_R2;
            P_W1:    phase_nxt = P_W2;
            P_W2:    phase_nxt = P_W3;
            default: phase_nxt = P_IDLE;
        endcase
        if (accept) begin
            phase_nxt = wr ? P_W1 : P_R1;
        end
    end

    // Bus levels are decoded from the next phase so they are registered
    // and already valid in the first cycle of each phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= P_IDLE;
            ope     <= BUS_DIS;
            ctl     <= CTL_RD;
            ena     <= BUS_DIS;
            adr     <= '0;
            oe      <= 1'b0;
            wdata_q <= '0;
        end else begin
            phase <= phase_nxt;
            if (accept) begin
                adr     <= addr;
                wdata_q <= wdata;
            end
            case (phase_nxt)
                P_R1, P_R2: begin
                    ena <= BUS_EN;
                    ctl <= CTL_RD;
                    ope <= BUS_EN;
                    oe  <= 1'b0;
                end
                P_W1, P_W3: begin
                    ena <= BUS_EN;
                    ctl <= CTL_RD;
                    ope <= BUS_DIS;
                    oe  <= 1'b1;
                end
                P_W2: begin
                    ena <= BUS_EN;
                    ctl <= CTL_WR;
                    ope <= BUS_DIS;
                    oe  <= 1'b1;
                end
                default: begin
                    ena <= BUS_DIS;
                    ctl <= CTL_RD;
                    ope <= BUS_DIS;
                    oe  <= 1'b0;
                end
            endcase
        end
    end

    assign dat   = oe ? wdata_q : {DATA_W{1'bz}};
    assign rdata = dat;

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ processor core driving a 256x8 asynchronous RAM.
// Each instruction fetches A,B,C at pc, writes mem[B] = mem[B] - mem[A]
// and branches to C when the result is <= 0 (signed), else pc += 3.
// Every instruction takes 15 cycles; a taken branch onto itself halts.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   run             execute enable, sampled in IDLE and in BR
//   ope, ctl, ena   active-low RAM control bus (registered)
//   adr, dat        RAM address and bidirectional data
//   pc              current instruction address
//   busy            instruction in progress (FA..BR)
//   halted          core is in HALT
//
// state | meaning
// IDLE  | waiting for run
// FA    | read mem[pc]   -> op_a
// FB    | read mem[pc+1] -> op_b
// FC    | read mem[pc+2] -> op_c
// RA    | read mem[op_a] -> val_a
// RB    | read mem[op_b] -> val_b
// TA    | bus turnaround, nobody drives dat
// WSET  | address op_b, difference driven
// WSTB  | ctl low, RAM stores
// WREL  | ctl high, difference still driven
// BR    | update pc, continue or stop
// HALT  | self-branch seen, wait for reset
module subleq_ctrl
    import subleq_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_PC     = 8'd0,
    parameter bit                HALT_ON_SELF = 1'b1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              ope,
    output logic              ctl,
    output logic              ena,
    output logic [ADDR_W-1:0] adr,
    inout  wire  [DATA_W-1:0] dat,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [ADDR_W-1:0] op_a;
    logic [ADDR_W-1:0] op_b;
    logic [ADDR_W-1:0] op_c;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [DATA_W-1:0] diff;
    logic              leq;
    logic              self_halt;
    logic [ADDR_W-1:0] pc_next;

    logic              port_start;
    logic              port_wr;
    logic [ADDR_W-1:0] port_addr;
    logic              port_done;
    logic [DATA_W-1:0] port_rdata;

    assign diff      = val_b - val_a;
    assign leq       = is_leq(diff);
    assign self_halt = HALT_ON_SELF && leq && (op_c == pc);
    assign pc_next   = leq ? op_c : pc + 8'd3;

    assign busy   = (state != IDLE) && (state != HALT);
    assign halted = (state == HALT);

    // The next access is launched on the same edge the FSM enters its
    // state, so the port's registered bus is valid from that state's
    // first cycle.
    always_comb begin
        state_nxt  = state;
        port_start = 1'b0;
        port_wr    = 1'b0;
        port_addr  = pc;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt  = FA;
                    port_start = 1'b1;
                    port_addr  = pc;
                end
            end
            FA: begin
                if (port_done) begin
                    state_nxt  = FB;
                    port_start = 1'b1;
                    port_addr  = pc + 8'd1;
                end
            end
            FB: begin
                if (port_done) begin
                    state_nxt  = FC;
                    port_start = 1'b1;
                    port_addr  = pc + 8'd2;
                end
            end
            FC: begin
                if (port_done) begin
                    state_nxt  = RA;
                    port_start = 1'b1;
                    port_addr  = op_a;
                end
            end
            RA: begin
                if (port_done) begin
                    state_nxt  = RB;
                    port_start = 1'b1;
                    port_addr  = op_b;
                end
            end
            RB: begin
                if (port_done) begin
                    state_nxt = TA;
                end
            end
            TA: begin
                state_nxt  = WSET;
                port_start = 1'b1;
                port_wr    = 1'b1;
                port_addr  = op_b;
            end
            WSET: state_nxt = WSTB;
            WSTB: state_nxt = WREL;
            WREL: begin
                if (port_done) begin
                    state_nxt = BR;
                end
            end
            BR: begin
                if (self_halt) begin
                    state_nxt = HALT;
                end else if (run) begin
                    state_nxt  = FA;
                    port_start = 1'b1;
                    port_addr  = pc_next;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= START_PC;
            op_a  <= '0;
            op_b  <= '0;
            op_c  <= '0;
            val_a <= '0;
            val_b <= '0;
        end else begin
            state <= state_nxt;
            if ((state == BR) && !self_halt) begin
                pc <= pc_next;
            end
            if (port_done) begin
                case (state)
                    FA:      op_a  <= port_rdata;
                    FB:      op_b  <= port_rdata;
                    FC:      op_c  <= port_rdata;
                    RA:      val_a <= port_rdata;
                    RB:      val_b <= port_rdata;
                    default: ;
                endcase
            end
        end
    end

    subleq_ram_port u_port (
        .clk   (clk),
        .rst   (rst),
        .start (port_start),
        .wr    (port_wr),
        .addr  (port_addr),
        .wdata (diff),
        .done  (port_done),
        .rdata (port_rdata),
        .ope   (ope),
        .ctl   (ctl),
        .ena   (ena),
        .adr   (adr),
        .dat   (dat)
    );

endmodule

// File: tb/tb_subleq_ctrl.sv
module tb_subleq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic       ope;
    logic       ctl;
    logic       ena;
    logic [7:0] adr;
    wire  [7:0] dat;
    logic [7:0] pc;
    logic       busy;
    logic       halted;

    always #5 clk = ~clk;

    subleq_ctrl #(.START_PC(8'd0), .HALT_ON_SELF(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .ope    (ope),
        .ctl    (ctl),
        .ena    (ena),
        .adr    (adr),
        .dat    (dat),
        .pc     (pc),
        .busy   (busy),
        .halted (halted)
    );

    // Asynchronous RAM model: reads while enabled and output-enabled,
    // stores on the falling edge of ctl while enabled.
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic       load = 1'b0;
    int         wr_count = 0;
    logic [7:0] last_wr_adr = 8'd0;
    int         bus_cnt = 0;

    assign dat = (!ena && !ope && ctl) ? mem[adr] : 8'hzz;

    always @(negedge ctl or posedge load) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] = img[i];
        end else if (!ena) begin
            mem[adr] = dat;
            wr_count++;
            last_wr_adr = adr;
        end
    end

    always @(negedge clk) if (!ena) bus_cnt++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'd0;
    endtask

    task automatic load_img();
        load = 1'b1;
        #1;
        load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state
    logic [7:0] rm [256];
    logic [7:0] rpc, ra, rb, rc, rd, p1, p2;
    logic       rhalt;

    int w0, w1, b0, cyc, bad;
    logic found;

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ope", ope, 1);
        check("rst_ctl", ctl, 1);
        check("rst_ena", ena, 1);
        check("rst_adr", adr, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        rst = 1'b0;

        // Taken, not-taken and halting instructions in sequence
        clear_img();
        img[0] = 8'd10; img[1] = 8'd12; img[2] = 8'd3;
        img[10] = 8'd3; img[12] = 8'd0;
        img[3] = 8'd12; img[4] = 8'd11; img[5] = 8'd6; img[11] = 8'd2;
        img[6] = 8'd12; img[7] = 8'd12; img[8] = 8'd6;
        load_img();
        @(negedge clk);
        w0 = wr_count;
        run = 1'b1;
        repeat (15) @(negedge clk);
        check("taken_busy_in_br", busy, 1);
        check("taken_pc_before_br", pc, 0);
        check("taken_mem12", mem[12], 8'hFD);
        @(negedge clk);
        check("taken_pc", pc, 3);
        check("taken_wr_count", wr_count - w0, 1);
        check("taken_wr_adr", last_wr_adr, 12);
        repeat (15) @(negedge clk);
        check("nt_pc", pc, 6);
        check("nt_mem11", mem[11], 5);
        check("nt_mem12", mem[12], 8'hFD);
        repeat (15) @(negedge clk);
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_pc", pc, 6);
        check("halt_mem12", mem[12], 0);
        check("halt_wr_total", wr_count - w0, 3);
        b0 = bus_cnt;
        w1 = wr_count;
        repeat (50) @(negedge clk);
        check("halt_no_bus", bus_cnt - b0, 0);
        check("halt_no_write", wr_count - w1, 0);
        check("halt_pc_hold", pc, 6);
        check("halt_still", halted, 1);

        // Wrap of pc and operand addresses, 8-bit overflow not taken
        run = 1'b0;
        do_reset();
        clear_img();
        img[0] = 8'd40; img[1] = 8'd40; img[2] = 8'hFE; img[40] = 8'd9;
        img[8'hFE] = 8'd20; img[8'hFF] = 8'd21;
        img[20] = 8'd1; img[21] = 8'h80;
        load_img();
        @(negedge clk);
        run = 1'b1;
        repeat (16) @(negedge clk);
        check("wrap_pc_fe", pc, 8'hFE);
        check("wrap_mem40", mem[40], 0);
        repeat (15) @(negedge clk);
        check("wrap_pc_01", pc, 8'h01);
        check("wrap_mem21", mem[21], 8'h7F);
        check("wrap_mem20", mem[20], 8'h01);
        run = 1'b0;
        repeat (15) @(negedge clk);
        check("stop_pc", pc, 4);
        check("stop_busy", busy, 0);
        check("stop_halted", halted, 0);
        repeat (10) @(negedge clk);
        check("stop_idle_pc", pc, 4);
        check("stop_idle_busy", busy, 0);

        // Reset during WSET: no write reaches the RAM
        do_reset();
        clear_img();
        img[0] = 8'd10; img[1] = 8'd12; img[2] = 8'd3;
        img[10] = 8'd3; img[12] = 8'd7;
        load_img();
        @(negedge clk);
        w0 = wr_count;
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (!ena && ope && ctl) found = 1'b1;
        end
        check("wset_seen", found, 1);
        rst = 1'b1;
        #1;
        check("abort_ope", ope, 1);
        check("abort_ctl", ctl, 1);
        check("abort_ena", ena, 1);
        check("abort_busy", busy, 0);
        check("abort_pc", pc, 0);
        @(negedge clk);
        run = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("wset_abort_mem", mem[12], 7);
        check("wset_abort_wr", wr_count - w0, 0);

        // Reset during WREL: the write has already landed
        load_img();
        @(negedge clk);
        w0 = wr_count;
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (wr_count != w0) found = 1'b1;
        end
        check("wstb_seen", found, 1);
        @(negedge clk);
        check("wrel_bus", {ena, ope, ctl}, 3'b011);
        rst = 1'b1;
        #1;
        check("wrel_abort_ena", ena, 1);
        check("wrel_abort_busy", busy, 0);
        check("wrel_abort_mem", mem[12], 4);
        check("wrel_abort_adr", last_wr_adr, 12);
        @(negedge clk);
        run = 1'b0;
        rst = 1'b0;

        // Random programs, single-stepped against the reference model
        for (int prog = 0; prog < 4; prog++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                img[i] = 8'($urandom_range(0, 255));
                rm[i] = img[i];
            end
            load_img();
            rpc = 8'd0;
            rhalt = 1'b0;
            for (int k = 0; k < 12 && !rhalt; k++) begin
                p1 = rpc + 8'd1;
                p2 = rpc + 8'd2;
                ra = rm[rpc];
                rb = rm[p1];
                rc = rm[p2];
                rd = rm[rb] - rm[ra];
                rm[rb] = rd;
                if ($signed(rd) <= 0) begin
                    if (rc == rpc) rhalt = 1'b1;
                    else rpc = rc;
                end else begin
                    rpc = rpc + 8'd3;
                end

                @(negedge clk);
                w0 = wr_count;
                run = 1'b1;
                @(negedge clk);
                run = 1'b0;
                cyc = 0;
                while (busy && cyc < 40) begin
                    cyc++;
                    @(negedge clk);
                end
                check("rnd_latency", cyc, 15);
                check("rnd_pc", pc, rpc);
                check("rnd_halted", halted, rhalt);
                check("rnd_wr_count", wr_count - w0, 1);
                check("rnd_wr_adr", last_wr_adr, rb);
                bad = 0;
                for (int i = 0; i < 256; i++) if (mem[i] !== rm[i]) bad++;
                check("rnd_mem", bad, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
